can_bit_destuffer: RTL and testbench

- Consumes the recovered baud clock and lock flag from the baud clock recovery stage, plus the CAN rx line.
- Samples rx once per bit at the baud rising edge, which falls at mid-bit because baud negedges align to rx edges.
- Tracks bus idle and start-of-frame, removes stuff bits and flags stuff violations.
- Delivers a destuffed bit stream with a valid strobe to the downstream frame decoder.

---
 rtl/can_bit_destuffer_if.sv | 23 ++
 rtl/can_bit_destuffer.sv | 144 ++++++++++++++
 tb/tb_can_bit_destuffer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_bit_destuffer_if.sv
// rtl/can_bit_destuffer_if.sv - bit-level link between baud recovery, destuffer and frame decoder
interface can_bit_destuffer_if;
  logic rx;
  logic baud;
  logic lock;
  logic stuff_en;
  logic frame_done;
  logic bit_out;
  logic bit_valid;
  logic sof;
  logic bus_idle;
  logic stuff_err;

  modport master (
    output rx, baud, lock, stuff_en, frame_done,
    input  bit_out, bit_valid, sof, bus_idle, stuff_err
  );

  modport slave (
    input  rx, baud, lock, stuff_en, frame_done,
    output bit_out, bit_valid, sof, bus_idle, stuff_err
  );
endinterface

// File: rtl/can_bit_destuffer.sv
// rtl/can_bit_destuffer.sv - CAN bus idle/SOF tracking and stuff-bit removal
// Samples rx on each baud rising edge; all outputs are registered.
module can_bit_destuffer #(
  parameter int IDLE_BITS = 11,
  parameter int STUFF_LEN = 5,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  can_bit_destuffer_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0] IDLE_MAX  = CNT_WIDTH'(IDLE_BITS);
  localparam logic [CNT_WIDTH-1:0] STUFF_MAX = CNT_WIDTH'(STUFF_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    FRAME     = 2'd2,
    ERROR     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic                 last_bit_q, last_bit_d;
  logic                 baud_q;
  logic                 bit_out_q, bit_out_d;
  logic                 bit_valid_q, bit_valid_d;
  logic                 sof_q, sof_d;
  logic                 bus_idle_q, bus_idle_d;
  logic                 stuff_err_q, stuff_err_d;
  logic                 samp;
  logic                 s;
  logic [CNT_WIDTH-1:0] idle_inc;

  assign samp     = bus.baud & ~baud_q & bus.lock;
  assign s        = bus.rx;
  assign idle_inc = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    run_cnt_d   = run_cnt_q;
    last_bit_d  = last_bit_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    sof_d       = 1'b0;
    stuff_err_d = 1'b0;

    if (!bus.lock) begin
      state_d    = WAIT_IDLE;
      idle_cnt_d = '0;
      run_cnt_d  = '0;
    end else if (bus.frame_done && state_q == FRAME) begin
      // frame_done beats a coincident sample
      state_d    = WAIT_IDLE;
      idle_cnt_d = '0;
    end else if (samp) begin
      unique case (state_q)
        WAIT_IDLE, ERROR: begin
          if (s) begin
            idle_cnt_d = idle_inc;
            if (idle_inc == IDLE_MAX) state_d = IDLE;
          end else begin
            idle_cnt_d = '0;
          end
        end
        IDLE: begin
          if (!s) begin
            bit_out_d   = 1'b0;
            bit_valid_d = 1'b1;
            sof_d       = 1'b1;
            run_cnt_d   = CNT_ONE;
            last_bit_d  = 1'b0;
            state_d     = FRAME;
          end
        end
        FRAME: begin
          if (!bus.stuff_en) begin
            bit_out_d   = s;
            bit_valid_d = 1'b1;
            run_cnt_d   = '0;
          end else if (run_cnt_q == STUFF_MAX) begin
            if (s != last_bit_q) begin
              run_cnt_d  = CNT_ONE;
              last_bit_d = s;
            end else begin
              stuff_err_d = 1'b1;
              idle_cnt_d  = '0;
              state_d     = ERROR;
            end
          end else begin
            bit_out_d   = s;
            bit_valid_d = 1'b1;
            if (s == last_bit_q) begin
              run_cnt_d = run_cnt_q + CNT_ONE;
            end else begin
              run_cnt_d  = CNT_ONE;
              last_bit_d = s;
            end
          end
        end
        default: state_d = WAIT_IDLE;
      endcase
    end

    bus_idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_IDLE;
      idle_cnt_q  <= '0;
      run_cnt_q   <= '0;
      last_bit_q  <= 1'b1;
      baud_q      <= 1'b0;
      bit_out_q   <= 1'b1;
      bit_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      bus_idle_q  <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      run_cnt_q   <= run_cnt_d;
      last_bit_q  <= last_bit_d;
      baud_q      <= bus.baud;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      sof_q       <= sof_d;
      bus_idle_q  <= bus_idle_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.sof       = sof_q;
  assign bus.bus_idle  = bus_idle_q;
  assign bus.stuff_err = stuff_err_q;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// tb/tb_can_bit_destuffer.sv - directed and randomized bench for can_bit_destuffer
module tb_can_bit_destuffer;

  localparam int IDLE_BITS = 11;
  localparam int STUFF_LEN = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  can_bit_destuffer_if dut_if ();

  can_bit_destuffer #(.IDLE_BITS(IDLE_BITS), .STUFF_LEN(STUFF_LEN), .CNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_sof   = 0;

  // Reference: mode 0 waiting for idle, 1 idle, 2 in frame, 3 after stuff error
  int m_mode = 0;
  int m_ones = 0;
  bit m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic bit run_full();
    if (m_q.size() < STUFF_LEN) return 1'b0;
    foreach (m_q[i]) if (m_q[i] != m_q[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_ones = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit s, input bit se, input bit fd, input bit lk,
                            output bit ev, output bit eb, output bit es, output bit ee);
    ev = 0; eb = 0; es = 0; ee = 0;
    if (!lk) begin
      model_reset();
      return;
    end
    if (fd && m_mode == 2) begin
      m_mode = 0;
      m_ones = 0;
      return;
    end
    case (m_mode)
      0, 3: begin
        m_ones = s ? ((m_ones < IDLE_BITS) ? m_ones + 1 : m_ones) : 0;
        if (m_ones == IDLE_BITS) m_mode = 1;
      end
      1: if (!s) begin
        ev = 1; eb = 0; es = 1;
        m_q.delete();
        m_q.push_back(1'b0);
        m_mode = 2;
      end
      default: begin
        if (!se) begin
          ev = 1; eb = s;
          m_q.delete();
        end else if (run_full()) begin
          if (s != m_q[$]) begin
            m_q.delete();
            m_q.push_back(s);
          end else begin
            ee = 1;
            m_mode = 3;
            m_ones = 0;
          end
        end else begin
          ev = 1; eb = s;
          if (m_q.size() > 0 && s != m_q[$]) m_q.delete();
          m_q.push_back(s);
          if (m_q.size() > STUFF_LEN) void'(m_q.pop_front());
        end
      end
    endcase
  endtask

  task automatic send_bit(input bit b, input bit se, input bit fd);
    bit ev, eb, es, ee;
    @(negedge clk);
    dut_if.baud = 1'b0;
    dut_if.rx = b;
    dut_if.stuff_en = se;
    repeat (3) @(negedge clk);
    dut_if.baud = 1'b1;
    dut_if.frame_done = fd;
    model_step(b, se, fd, dut_if.lock, ev, eb, es, ee);
    @(negedge clk);
    dut_if.frame_done = 1'b0;
    chk("bit_valid", dut_if.bit_valid, ev);
    chk("sof", dut_if.sof, es);
    chk("stuff_err", dut_if.stuff_err, ee);
    chk("bus_idle", dut_if.bus_idle, (m_mode == 1));
    if (ev) chk("bit_out", dut_if.bit_out, eb);
    n_valid += int'(dut_if.bit_valid);
    n_err   += int'(dut_if.stuff_err);
    n_sof   += int'(dut_if.sof);
    @(negedge clk);
    chk("valid_1clk", dut_if.bit_valid, 1'b0);
    chk("sof_1clk", dut_if.sof, 1'b0);
    chk("err_1clk", dut_if.stuff_err, 1'b0);
    @(negedge clk);
  endtask

  task automatic pulse_fd();
    @(negedge clk);
    dut_if.frame_done = 1'b1;
    if (m_mode == 2) begin
      m_mode = 0;
      m_ones = 0;
    end
    @(negedge clk);
    dut_if.frame_done = 1'b0;
    chk("bus_idle_fd", dut_if.bus_idle, (m_mode == 1));
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_seq(input logic [15:0] bits, input int len, input bit se);
    logic [15:0] v;
    v = bits;
    for (int i = len - 1; i >= 0; i--) send_bit(v[i], se, 1'b0);
  endtask

  int  v0, e0, len;
  bit  b, se;

  initial begin
    dut_if.rx = 1'b1;
    dut_if.baud = 1'b0;
    dut_if.lock = 1'b0;
    dut_if.stuff_en = 1'b1;
    dut_if.frame_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bit_out", dut_if.bit_out, 1'b1);
    chk("rst_valid", dut_if.bit_valid, 1'b0);
    chk("rst_sof", dut_if.sof, 1'b0);
    chk("rst_idle", dut_if.bus_idle, 1'b0);
    chk("rst_err", dut_if.stuff_err, 1'b0);
    rst = 1'b0;
    dut_if.lock = 1'b1;
    model_reset();

    send_ones(10);
    chk("idle_after_10", dut_if.bus_idle, 1'b0);
    send_ones(1);
    chk("idle_after_11", dut_if.bus_idle, 1'b1);

    v0 = n_valid; e0 = n_sof;
    send_seq(16'b01011, 5, 1'b1);
    chk("sof_data_count", n_valid - v0, 5);
    chk("sof_count", n_sof - e0, 1);
    pulse_fd();
    send_ones(11);

    v0 = n_valid; e0 = n_err;
    send_seq(16'b00000101, 8, 1'b1);
    chk("stuff0_count", n_valid - v0, 7);
    chk("stuff0_err", n_err - e0, 0);
    pulse_fd();
    send_ones(11);

    v0 = n_valid; e0 = n_err;
    send_seq(16'b01111101, 8, 1'b1);
    chk("stuff1_count", n_valid - v0, 7);
    chk("stuff1_err", n_err - e0, 0);
    pulse_fd();
    send_ones(11);

    v0 = n_valid; e0 = n_err;
    send_seq(16'b000000, 6, 1'b1);
    chk("err_count", n_err - e0, 1);
    chk("err_valid", n_valid - v0, 5);
    pulse_fd();
    send_ones(10);
    chk("err_idle_10", dut_if.bus_idle, 1'b0);
    send_ones(1);
    chk("err_idle_11", dut_if.bus_idle, 1'b1);

    send_bit(1'b0, 1'b1, 1'b0);
    v0 = n_valid; e0 = n_err;
    send_seq(16'h03ff, 10, 1'b0);
    chk("nostuff_count", n_valid - v0, 10);
    chk("nostuff_err", n_err - e0, 0);
    pulse_fd();
    chk("nostuff_wait", dut_if.bus_idle, 1'b0);
    send_ones(11);

    send_seq(16'b011, 3, 1'b1);
    v0 = n_valid;
    send_bit(1'b0, 1'b1, 1'b1);
    chk("fd_drop_samp", n_valid - v0, 0);
    send_ones(11);

    send_seq(16'b0110, 4, 1'b1);
    @(negedge clk);
    dut_if.lock = 1'b0;
    v0 = n_valid; e0 = n_err;
    send_seq(16'b000000, 6, 1'b1);
    chk("lock_valid", n_valid - v0, 0);
    chk("lock_err", n_err - e0, 0);
    dut_if.lock = 1'b1;
    send_ones(10);
    chk("lock_idle_10", dut_if.bus_idle, 1'b0);
    send_ones(1);

    for (int f = 0; f < 20; f++) begin
      send_bit(1'b0, 1'b1, 1'b0);
      len = int'($urandom_range(8, 40));
      b = 1'b0;
      se = 1'b1;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) b = ~b;
        if ($urandom_range(0, 9) == 0) se = ~se;
        send_bit(b, se, 1'b0);
      end
      pulse_fd();
      send_ones(11);
      chk("rand_idle", dut_if.bus_idle, 1'b1);
    end

    send_seq(16'b0110, 4, 1'b1);
    chk("pre_rst_bit_out", dut_if.bit_out, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_bit_out", dut_if.bit_out, 1'b1);
    chk("arst_valid", dut_if.bit_valid, 1'b0);
    chk("arst_idle", dut_if.bus_idle, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_ones(11);
    chk("idle_again", dut_if.bus_idle, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_idle_drop", dut_if.bus_idle, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
